// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, error codes and init-checker state encoding.
// The controller init/refresh blocks use the same constants.
package sdram_pkg;

  // Command bus width and address width
  localparam int CMD_W     = 4;
  localparam int ADDR_W    = 13;
  localparam int PWR_CNT_W = 15;
  localparam int GAP_CNT_W = 4;

  // {cs_n, ras_n, cas_n, we_n} encodings
  localparam logic [CMD_W-1:0] CMD_NOP  = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_PRE  = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_AREF = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_MSET = 4'b0000;

  // Violation codes; 0 and 7 are reserved
  localparam logic [2:0] ERR_NONE          = 3'd0;
  localparam logic [2:0] ERR_EARLY         = 3'd1;
  localparam logic [2:0] ERR_ORDER         = 3'd2;
  localparam logic [2:0] ERR_TIMING        = 3'd3;
  localparam logic [2:0] ERR_PRE_NOT_ALL   = 3'd4;
  localparam logic [2:0] ERR_MODE_MISMATCH = 3'd5;
  localparam logic [2:0] ERR_ILLEGAL       = 3'd6;

  typedef enum logic [2:0] {
    KIND_NOP,
    KIND_PRE,
    KIND_AREF,
    KIND_MSET,
    KIND_OTHER
  } cmd_kind_e;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_WAIT_PRE,
    ST_WAIT_AREF,
    ST_GAP,
    ST_MRD,
    ST_READY,
    ST_ERROR
  } init_state_e;

  // Deselect (cs_n=1) is folded into NOP; any unlisted selected code is OTHER
  function automatic cmd_kind_e decodeCmd(input logic [CMD_W-1:0] code);
    cmd_kind_e kind;
    if (code[3] || code == CMD_NOP) begin
      kind = KIND_NOP;
    end else if (code == CMD_PRE) begin
      kind = KIND_PRE;
    end else if (code == CMD_AREF) begin
      kind = KIND_AREF;
    end else if (code == CMD_MSET) begin
      kind = KIND_MSET;
    end else begin
      kind = KIND_OTHER;
    end
    return kind;
  endfunction

endpackage

// File: rtl/sdram_gap_timer.sv
// Loadable down-counter with zero and last-cycle flags. Shared by the
// PRE/AREF spacing window and the mode-register settle window.
module sdram_gap_timer
  import sdram_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [GAP_CNT_W-1:0] loadVal_i,
  output logic                 zero_o,
  output logic                 last_o
);

  logic [GAP_CNT_W-1:0] cnt_q;
  logic [GAP_CNT_W-1:0] cnt_d;

  // Load wins over counting; the counter parks at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = loadVal_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
  assign last_o = (cnt_q == GAP_CNT_W'(1));

endmodule

// File: rtl/sdram_init_checker.sv
// Responder-side checker for the SDRAM power-up sequence: watches the
// command bus, enforces the NOP wait, precharge-all, refresh count/spacing
// and mode-register set, then raises dev_ready or latches a sticky error.
module sdram_init_checker
  import sdram_pkg::*;
#(
  parameter int               DELAY_200US = 20000,
  parameter int               T_RP        = 2,
  parameter int               T_RC        = 8,
  parameter int               T_MRD       = 2,
  parameter int               AREF_REQ    = 2,
  parameter logic [ADDR_W-1:0] MODE_EXPECT = 13'h032
) (
  input  logic              sclk,
  input  logic              s_rst,
  input  logic [CMD_W-1:0]  cmd,
  input  logic [ADDR_W-1:0] sdram_addr,
  output logic              dev_ready,
  output logic [ADDR_W-1:0] mode_reg,
  output logic [3:0]        aref_cnt,
  output logic              err,
  output logic [2:0]        err_code
);

  // Parameters must fit the fixed counter widths
  if (DELAY_200US < 1 || DELAY_200US > (2**PWR_CNT_W) - 1) begin : gDelayCheck
    $error("DELAY_200US does not fit the powerup counter");
  end
  if (T_RP < 2 || T_RP > 2**GAP_CNT_W) begin : gRpCheck
    $error("T_RP does not fit the gap counter");
  end
  if (T_RC < 2 || T_RC > 2**GAP_CNT_W) begin : gRcCheck
    $error("T_RC does not fit the gap counter");
  end
  if (T_MRD < 1 || T_MRD > (2**GAP_CNT_W) - 1) begin : gMrdCheck
    $error("T_MRD does not fit the gap counter");
  end
  if (AREF_REQ < 0 || AREF_REQ > 15) begin : gArefCheck
    $error("AREF_REQ does not fit the refresh counter");
  end

  localparam logic [PWR_CNT_W-1:0] PwrLast = PWR_CNT_W'(DELAY_200US - 1);
  localparam logic [GAP_CNT_W-1:0] RpLoad  = GAP_CNT_W'(T_RP - 1);
  localparam logic [GAP_CNT_W-1:0] RcLoad  = GAP_CNT_W'(T_RC - 1);
  localparam logic [GAP_CNT_W-1:0] MrdLoad = GAP_CNT_W'(T_MRD);
  localparam logic [3:0]           ArefReq = 4'(AREF_REQ);

  init_state_e          state_q;
  logic [PWR_CNT_W-1:0] pwrCnt_q;
  logic                 devReady_q;
  logic                 err_q;
  logic [2:0]           errCode_q;
  logic [ADDR_W-1:0]    modeReg_q;
  logic [3:0]           arefCnt_q;

  cmd_kind_e            kind;
  logic                 preAll;
  logic                 arefMet;
  logic                 modeOk;
  logic                 viol;
  logic [2:0]           violCode;
  logic                 timerLoad;
  logic [GAP_CNT_W-1:0] timerLoadVal;
  logic                 timerZero;
  logic                 timerLast;

  // Decode the bus and decide whether this edge's command is a violation
  always_comb begin
    kind     = decodeCmd(cmd);
    preAll   = sdram_addr[10];
    arefMet  = (arefCnt_q >= ArefReq);
    modeOk   = (sdram_addr == MODE_EXPECT);
    viol     = 1'b0;
    violCode = ERR_NONE;
    case (state_q)
      ST_POWERUP: begin
        if (kind != KIND_NOP) begin
          viol     = 1'b1;
          violCode = ERR_EARLY;
        end
      end
      ST_WAIT_PRE: begin
        case (kind)
          KIND_PRE: begin
            if (!preAll) begin
              viol     = 1'b1;
              violCode = ERR_PRE_NOT_ALL;
            end
          end
          KIND_AREF, KIND_MSET: begin
            viol     = 1'b1;
            violCode = ERR_ORDER;
          end
          KIND_OTHER: begin
            viol     = 1'b1;
            violCode = ERR_ILLEGAL;
          end
          default: ;
        endcase
      end
      ST_WAIT_AREF: begin
        case (kind)
          KIND_PRE: begin
            if (!preAll) begin
              viol     = 1'b1;
              violCode = ERR_PRE_NOT_ALL;
            end
          end
          KIND_MSET: begin
            if (!arefMet) begin
              viol     = 1'b1;
              violCode = ERR_ORDER;
            end else if (!modeOk) begin
              viol     = 1'b1;
              violCode = ERR_MODE_MISMATCH;
            end
          end
          KIND_OTHER: begin
            viol     = 1'b1;
            violCode = ERR_ILLEGAL;
          end
          default: ;
        endcase
      end
      ST_GAP: begin
        if (kind != KIND_NOP && !timerZero) begin
          viol     = 1'b1;
          violCode = ERR_TIMING;
        end
      end
      ST_MRD: begin
        if (kind != KIND_NOP && !timerLast && !timerZero) begin
          viol     = 1'b1;
          violCode = ERR_TIMING;
        end
      end
      default: ;
    endcase
  end

  // Start the spacing window on each accepted PRE/AREF/MSET
  always_comb begin
    timerLoad    = 1'b0;
    timerLoadVal = '0;
    if (!viol) begin
      if ((state_q == ST_WAIT_PRE || state_q == ST_WAIT_AREF) && kind == KIND_PRE) begin
        timerLoad    = 1'b1;
        timerLoadVal = RpLoad;
      end else if (state_q == ST_WAIT_AREF && kind == KIND_AREF) begin
        timerLoad    = 1'b1;
        timerLoadVal = RcLoad;
      end else if (state_q == ST_WAIT_AREF && kind == KIND_MSET) begin
        timerLoad    = 1'b1;
        timerLoadVal = MrdLoad;
      end
    end
  end

  sdram_gap_timer uGapTimer (
    .clk_i     (sclk),
    .rst_i     (s_rst),
    .load_i    (timerLoad),
    .loadVal_i (timerLoadVal),
    .zero_o    (timerZero),
    .last_o    (timerLast)
  );

  // Init-sequence FSM; a violation on an edge overrides any state advance
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state_q    <= ST_POWERUP;
      pwrCnt_q   <= '0;
      devReady_q <= 1'b0;
      err_q      <= 1'b0;
      errCode_q  <= ERR_NONE;
      modeReg_q  <= '0;
      arefCnt_q  <= '0;
    end else begin
      if (state_q == ST_WAIT_AREF && kind == KIND_MSET && arefMet) begin
        modeReg_q <= sdram_addr;
      end
      if (viol) begin
        state_q   <= ST_ERROR;
        err_q     <= 1'b1;
        errCode_q <= violCode;
      end else begin
        case (state_q)
          ST_POWERUP: begin
            if (pwrCnt_q != '1) begin
              pwrCnt_q <= pwrCnt_q + 1'b1;
            end
            if (pwrCnt_q == PwrLast) begin
              state_q <= ST_WAIT_PRE;
            end
          end
          ST_WAIT_PRE: begin
            if (kind == KIND_PRE) begin
              state_q <= ST_GAP;
            end
          end
          ST_WAIT_AREF: begin
            if (kind == KIND_PRE) begin
              state_q <= ST_GAP;
            end else if (kind == KIND_AREF) begin
              if (arefCnt_q != 4'hF) begin
                arefCnt_q <= arefCnt_q + 1'b1;
              end
              state_q <= ST_GAP;
            end else if (kind == KIND_MSET) begin
              state_q <= ST_MRD;
            end
          end
          ST_GAP: begin
            if (timerLast || timerZero) begin
              state_q <= ST_WAIT_AREF;
            end
          end
          ST_MRD: begin
            if (timerLast || timerZero) begin
              state_q    <= ST_READY;
              devReady_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign dev_ready = devReady_q;
  assign mode_reg  = modeReg_q;
  assign aref_cnt  = arefCnt_q;
  assign err       = err_q;
  assign err_code  = errCode_q;

endmodule

// File: tb/tb_sdram_init_checker.sv
// Self-checking bench for sdram_init_checker: directed vector table,
// hand-written multi-cycle sequences, and randomized init sequences checked
// every cycle against a timestamp-based reference model.
module tb_sdram_init_checker;

  // Powerup wait shortened so many full sequences fit in the run
  localparam int          TbDelay  = 300;
  localparam int          TRp      = 2;
  localparam int          TRc      = 8;
  localparam int          TMrd     = 2;
  localparam int          ArefReq  = 2;
  localparam logic [12:0] ModeExp  = 13'h032;

  localparam logic [3:0] NopC  = 4'b0111;
  localparam logic [3:0] PreC  = 4'b0010;
  localparam logic [3:0] ArefC = 4'b0001;
  localparam logic [3:0] MsetC = 4'b0000;
  localparam logic [3:0] ActC  = 4'b0011;
  localparam logic [3:0] WrC   = 4'b0100;
  localparam logic [12:0] A10  = 13'h400;

  logic        sclk = 1'b0;
  logic        s_rst = 1'b1;
  logic [3:0]  cmd = 4'b0111;
  logic [12:0] sdram_addr = '0;
  logic        dev_ready;
  logic [12:0] mode_reg;
  logic [3:0]  aref_cnt;
  logic        err;
  logic [2:0]  err_code;

  int checkCount = 0;
  int passCount  = 0;
  int cyc        = 0;

  // Reference model state: timestamps of the last accepted commands
  bit          mErr;
  bit          mReady;
  bit          mPre;
  logic [2:0]  mCode;
  int          mAref;
  logic [12:0] mMode;
  int          mLastT;
  int          mLastGap;
  int          mMsetT;

  typedef struct packed {
    logic [3:0]       nCmd;
    logic [4:0][7:0]  off;
    logic [4:0][3:0]  c;
    logic [4:0][12:0] a;
    logic             expReady;
    logic             expErr;
    logic [2:0]       expCode;
    logic [3:0]       expAref;
    logic [12:0]      expMode;
  } vec_t;

  localparam int NumVec = 11;
  vec_t vecs [NumVec];

  logic [3:0]  rc;
  logic [12:0] ra;
  int          rg;

  sdram_init_checker #(
    .DELAY_200US (TbDelay),
    .T_RP        (TRp),
    .T_RC        (TRc),
    .T_MRD       (TMrd),
    .AREF_REQ    (ArefReq),
    .MODE_EXPECT (ModeExp)
  ) dut (
    .sclk       (sclk),
    .s_rst      (s_rst),
    .cmd        (cmd),
    .sdram_addr (sdram_addr),
    .dev_ready  (dev_ready),
    .mode_reg   (mode_reg),
    .aref_cnt   (aref_cnt),
    .err        (err),
    .err_code   (err_code)
  );

  // Free-running clock
  always #5 sclk = ~sclk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s at cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic modelReset();
    mErr = 0; mReady = 0; mPre = 0; mCode = 3'd0; mAref = 0; mMode = '0;
    mLastT = -1; mLastGap = 0; mMsetT = -1; cyc = 0;
  endtask

  task automatic modelRaise(input logic [2:0] code);
    mErr  = 1;
    mCode = code;
  endtask

  // Apply the init rules to the command seen at cycle cyc
  task automatic modelStep(input logic [3:0] c, input logic [12:0] a);
    bit nonNop;
    nonNop = (c[3] == 1'b0) && (c != NopC);
    if (mErr || mReady) return;
    if (mMsetT >= 0) begin
      if (cyc - mMsetT >= TMrd) mReady = 1;
      else if (nonNop) modelRaise(3'd3);
      return;
    end
    if (!nonNop) return;
    if (cyc < TbDelay) begin
      modelRaise(3'd1);
      return;
    end
    if (mLastT >= 0 && cyc - mLastT < mLastGap) begin
      modelRaise(3'd3);
      return;
    end
    if (c == PreC) begin
      if (!a[10]) modelRaise(3'd4);
      else begin
        mPre = 1; mLastT = cyc; mLastGap = TRp;
      end
    end else if (c == ArefC) begin
      if (!mPre) modelRaise(3'd2);
      else begin
        if (mAref < 15) mAref++;
        mLastT = cyc; mLastGap = TRc;
      end
    end else if (c == MsetC) begin
      if (!mPre || mAref < ArefReq) modelRaise(3'd2);
      else begin
        mMode = a;
        if (a != ModeExp) modelRaise(3'd5);
        else mMsetT = cyc;
      end
    end else begin
      modelRaise(3'd6);
    end
  endtask

  // Drive one cycle, advance the model, compare every output
  task automatic applyStimulus(input logic [3:0] c, input logic [12:0] a, input logic r);
    cmd = c;
    sdram_addr = a;
    s_rst = r;
    @(posedge sclk);
    #1;
    if (r) modelReset();
    else begin
      modelStep(c, a);
      cyc++;
    end
    checkOutput("model dev_ready", 16'(dev_ready), 16'(mReady));
    checkOutput("model err",       16'(err),       16'(mErr));
    checkOutput("model err_code",  16'(err_code),  16'(mCode));
    checkOutput("model aref_cnt",  16'(aref_cnt),  16'(mAref));
    checkOutput("model mode_reg",  16'(mode_reg),  16'(mMode));
  endtask

  task automatic applyReset();
    applyStimulus(NopC, 13'h0, 1'b1);
  endtask

  task automatic runNops(input int n);
    for (int i = 0; i < n; i++) applyStimulus(NopC, 13'h0, 1'b0);
  endtask

  task automatic addStep(input int idx, input int o, input logic [3:0] c, input logic [12:0] a);
    int k;
    k = int'(vecs[idx].nCmd);
    vecs[idx].off[k] = 8'(o);
    vecs[idx].c[k]   = c;
    vecs[idx].a[k]   = a;
    vecs[idx].nCmd   = 4'(k + 1);
  endtask

  task automatic setExpect(input int idx, input logic r, input logic e, input logic [2:0] code,
                           input logic [3:0] ar, input logic [12:0] m);
    vecs[idx].expReady = r;
    vecs[idx].expErr   = e;
    vecs[idx].expCode  = code;
    vecs[idx].expAref  = ar;
    vecs[idx].expMode  = m;
  endtask

  // Run one vector: offsets are cycles after the powerup wait ends
  task automatic runVector(input int idx);
    int lastOff;
    int k;
    bit hit;
    applyReset();
    runNops(TbDelay);
    lastOff = int'(vecs[idx].off[int'(vecs[idx].nCmd) - 1]);
    k = 0;
    for (int t = 0; t <= lastOff + 6; t++) begin
      hit = (k < int'(vecs[idx].nCmd)) && (int'(vecs[idx].off[k]) == t);
      if (hit) begin
        applyStimulus(vecs[idx].c[k], vecs[idx].a[k], 1'b0);
        k++;
      end else begin
        applyStimulus(NopC, 13'h0, 1'b0);
      end
    end
    checkOutput($sformatf("vec%0d dev_ready", idx), 16'(dev_ready), 16'(vecs[idx].expReady));
    checkOutput($sformatf("vec%0d err", idx),       16'(err),       16'(vecs[idx].expErr));
    checkOutput($sformatf("vec%0d err_code", idx),  16'(err_code),  16'(vecs[idx].expCode));
    checkOutput($sformatf("vec%0d aref_cnt", idx),  16'(aref_cnt),  16'(vecs[idx].expAref));
    checkOutput($sformatf("vec%0d mode_reg", idx),  16'(mode_reg),  16'(vecs[idx].expMode));
  endtask

  task automatic fillVectors();
    for (int i = 0; i < NumVec; i++) vecs[i] = '0;
    // legal sequence
    addStep(0, 0, PreC, A10); addStep(0, 2, ArefC, 0); addStep(0, 10, ArefC, 0);
    addStep(0, 18, MsetC, 13'h032); setExpect(0, 1, 0, 3'd0, 4'd2, 13'h032);
    // second AREF one cycle short of T_RC, later MSET ignored
    addStep(1, 0, PreC, A10); addStep(1, 2, ArefC, 0); addStep(1, 9, ArefC, 0);
    addStep(1, 20, MsetC, 13'h032); setExpect(1, 0, 1, 3'd3, 4'd1, 13'h000);
    // MSET after only one refresh
    addStep(2, 0, PreC, A10); addStep(2, 2, ArefC, 0); addStep(2, 10, MsetC, 13'h032);
    setExpect(2, 0, 1, 3'd2, 4'd1, 13'h000);
    // precharge without A10
    addStep(3, 0, PreC, 13'h000); setExpect(3, 0, 1, 3'd4, 4'd0, 13'h000);
    // wrong mode word still latched
    addStep(4, 0, PreC, A10); addStep(4, 2, ArefC, 0); addStep(4, 10, ArefC, 0);
    addStep(4, 18, MsetC, 13'h022); setExpect(4, 0, 1, 3'd5, 4'd2, 13'h022);
    // ACTIVE while waiting for precharge
    addStep(5, 0, ActC, 0); setExpect(5, 0, 1, 3'd6, 4'd0, 13'h000);
    // refresh before precharge
    addStep(6, 0, ArefC, 0); setExpect(6, 0, 1, 3'd2, 4'd0, 13'h000);
    // refresh one cycle inside T_RP
    addStep(7, 0, PreC, A10); addStep(7, 1, ArefC, 0); setExpect(7, 0, 1, 3'd3, 4'd0, 13'h000);
    // WRITE while waiting for refresh
    addStep(8, 0, PreC, A10); addStep(8, 3, WrC, 0); setExpect(8, 0, 1, 3'd6, 4'd0, 13'h000);
    // command inside the mode-register settle window
    addStep(9, 0, PreC, A10); addStep(9, 2, ArefC, 0); addStep(9, 10, ArefC, 0);
    addStep(9, 18, MsetC, 13'h032); addStep(9, 19, ArefC, 0);
    setExpect(9, 0, 1, 3'd3, 4'd2, 13'h032);
    // extra refresh before a legal MSET
    addStep(10, 0, PreC, A10); addStep(10, 2, ArefC, 0); addStep(10, 10, ArefC, 0);
    addStep(10, 18, ArefC, 0); addStep(10, 26, MsetC, 13'h032);
    setExpect(10, 1, 0, 3'd0, 4'd3, 13'h032);
  endtask

  function automatic logic [3:0] randNop();
    logic [2:0] low;
    low = 3'($urandom_range(0, 7));
    return ($urandom_range(0, 1) == 0) ? NopC : {1'b1, low};
  endfunction

  task automatic randomTrials(input int n);
    for (int trial = 0; trial < n; trial++) begin
      applyReset();
      for (int i = 0; i < TbDelay - 3 + int'($urandom_range(0, 5)); i++) begin
        applyStimulus(randNop(), 13'($urandom_range(0, 8191)), 1'b0);
      end
      for (int s = 0; s < 4; s++) begin
        case (s)
          0: begin rc = PreC;  ra = ($urandom_range(0, 9) == 0) ? 13'h000 : A10; rg = 1; end
          1: begin rc = ArefC; ra = 13'h0; rg = int'($urandom_range(1, 3)); end
          2: begin rc = ArefC; ra = 13'h0; rg = int'($urandom_range(6, 9)); end
          default: begin
            rc = MsetC;
            ra = ($urandom_range(0, 6) == 0) ? 13'($urandom_range(0, 8191)) : ModeExp;
            rg = int'($urandom_range(6, 9));
          end
        endcase
        if ($urandom_range(0, 99) < 12) rc = 4'($urandom_range(0, 7));
        for (int i = 0; i < rg - 1; i++) applyStimulus(randNop(), 13'h0, 1'b0);
        applyStimulus(rc, ra, 1'b0);
      end
      runNops(6);
    end
  endtask

  initial begin
    int t0;
    modelReset();
    fillVectors();

    // Reset state
    applyReset();
    checkOutput("reset dev_ready", 16'(dev_ready), 16'h0);
    checkOutput("reset err",       16'(err),       16'h0);
    checkOutput("reset err_code",  16'(err_code),  16'h0);
    checkOutput("reset aref_cnt",  16'(aref_cnt),  16'h0);
    checkOutput("reset mode_reg",  16'(mode_reg),  16'h0);

    for (int i = 0; i < NumVec; i++) runVector(i);

    // PRE on the last cycle of the powerup wait
    applyReset();
    runNops(TbDelay - 1);
    applyStimulus(PreC, A10, 1'b0);
    checkOutput("early err",      16'(err),      16'h1);
    checkOutput("early err_code", 16'(err_code), 16'h1);
    runNops(1);
    applyStimulus(ArefC, 0, 1'b0); runNops(7);
    applyStimulus(ArefC, 0, 1'b0); runNops(7);
    applyStimulus(MsetC, ModeExp, 1'b0); runNops(6);
    checkOutput("early dev_ready", 16'(dev_ready), 16'h0);
    checkOutput("early err_code held", 16'(err_code), 16'h1);

    // Reset between the two refreshes, then a full legal replay
    applyReset();
    runNops(TbDelay);
    applyStimulus(PreC, A10, 1'b0); runNops(1);
    applyStimulus(ArefC, 0, 1'b0); runNops(2);
    applyReset();
    checkOutput("midrst aref_cnt", 16'(aref_cnt), 16'h0);
    checkOutput("midrst err",      16'(err),      16'h0);
    runNops(TbDelay);
    t0 = cyc;
    applyStimulus(PreC, A10, 1'b0); runNops(1);
    applyStimulus(ArefC, 0, 1'b0); runNops(7);
    applyStimulus(ArefC, 0, 1'b0); runNops(7);
    applyStimulus(MsetC, ModeExp, 1'b0);
    runNops(1);
    checkOutput("replay ready at t0+19", 16'(dev_ready), 16'h0);
    runNops(1);
    checkOutput("replay ready at t0+20", 16'(dev_ready), 16'h1);
    checkOutput("replay cycle", 16'(cyc - t0), 16'd21);
    checkOutput("replay aref_cnt", 16'(aref_cnt), 16'h2);
    checkOutput("replay mode_reg", 16'(mode_reg), 16'(ModeExp));
    checkOutput("replay err",      16'(err),      16'h0);

    randomTrials(25);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
